// File: rtl/host_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// host_tx_arbiter_if : requester byte lanes plus the shared FIFO write port.
// Revision: 1.0
// ============================================================================
interface host_tx_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]            req_valid_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i;
  logic [NUM_REQ-1:0]            req_last_i;
  logic [NUM_REQ-1:0]            req_ready_o;
  logic                          full_i;
  logic                          writereq_o;
  logic [DATA_WIDTH-1:0]         data_o;

  // Arbiter side.
  modport master (
    input  req_valid_i,
    input  req_data_i,
    input  req_last_i,
    input  full_i,
    output req_ready_o,
    output writereq_o,
    output data_o
  );

  // Requester / FIFO side.
  modport slave (
    output req_valid_i,
    output req_data_i,
    output req_last_i,
    output full_i,
    input  req_ready_o,
    input  writereq_o,
    input  data_o
  );
endinterface
`default_nettype wire

// File: rtl/host_tx_arbiter.sv
`default_nettype none
// ============================================================================
// host_tx_arbiter : per-packet round-robin owner of the outbound FIFO write port
//   with mid-packet watchdog. Define HOST_TX_ARB_STATS_EN for packet/stall counters.
// Revision: 1.0
// ============================================================================
module host_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int IDX_WIDTH   = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  host_tx_arbiter_if.master     bus,
  output logic [NUM_REQ-1:0]    grant_o,
  output logic                  busy_o,
  output logic                  timeout_o,
  output logic [IDX_WIDTH-1:0]  timeout_req_o
`ifdef HOST_TX_ARB_STATS_EN
  ,
  output logic [15:0]           pkt_count_o,
  output logic [15:0]           stall_count_o
`endif
);

  localparam int CNT_W      = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam int WDOG_LIMIT = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

  localparam logic [CNT_W-1:0]     c_wdog_limit = CNT_W'(WDOG_LIMIT);
  localparam logic [IDX_WIDTH:0]   c_num_req    = (IDX_WIDTH + 1)'(NUM_REQ);
  localparam logic [IDX_WIDTH-1:0] c_last_idx   = IDX_WIDTH'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0]   c_onehot0    = NUM_REQ'(1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_XFER = 1'b1
  } state_t;

  state_t                 state_q;
  logic [IDX_WIDTH-1:0]   rr_ptr_q;
  logic [IDX_WIDTH-1:0]   owner_q;
  logic [NUM_REQ-1:0]     grant_q;
  logic                   busy_q;
  logic                   timeout_q;
  logic [IDX_WIDTH-1:0]   timeout_req_q;
  logic [CNT_W-1:0]       wdog_q;
  logic [CNT_W-1:0]       wdog_d;

  logic                   w_xfer;
  logic                   w_own_valid;
  logic                   w_own_last;
  logic [DATA_WIDTH-1:0]  w_own_data;
  logic                   w_accept;
  logic                   w_done;
  logic                   w_idle_tick;
  logic                   w_abort;
  logic                   w_found;
  logic [IDX_WIDTH-1:0]   w_pick;
  logic [IDX_WIDTH:0]     w_slot;
  logic [IDX_WIDTH-1:0]   w_next_ptr;

  assign w_xfer      = (state_q == S_XFER);
  assign w_own_valid = bus.req_valid_i[owner_q];
  assign w_own_last  = bus.req_last_i[owner_q];
  assign w_own_data  = bus.req_data_i[owner_q*DATA_WIDTH +: DATA_WIDTH];

  assign w_accept    = w_xfer & w_own_valid & ~bus.full_i;
  assign w_done      = w_accept & w_own_last;
  // Backpressure cycles are not idle: only a starved, unblocked owner ages the watchdog.
  assign w_idle_tick = w_xfer & ~w_own_valid & ~bus.full_i;
  assign w_abort     = (TIMEOUT_CYC != 0) && w_idle_tick && (wdog_q == c_wdog_limit);
  assign w_next_ptr  = (owner_q == c_last_idx) ? '0 : owner_q + IDX_WIDTH'(1);

  // Descending scan so the slot closest to rr_ptr is the last (winning) assignment.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_slot  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_slot = {1'b0, rr_ptr_q} + (IDX_WIDTH + 1)'(i);
      if (w_slot >= c_num_req) begin
        w_slot = w_slot - c_num_req;
      end
      if (bus.req_valid_i[w_slot[IDX_WIDTH-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_slot[IDX_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    wdog_d = wdog_q;
    if (!w_xfer || w_accept || w_abort) begin
      wdog_d = '0;
    end else if (w_idle_tick && (TIMEOUT_CYC != 0)) begin
      wdog_d = wdog_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= '0;
      owner_q       <= '0;
      grant_q       <= '0;
      busy_q        <= 1'b0;
      timeout_q     <= 1'b0;
      timeout_req_q <= '0;
      wdog_q        <= '0;
    end else begin
      timeout_q <= 1'b0;
      wdog_q    <= wdog_d;
      case (state_q)
        S_IDLE: begin
          if (w_found) begin
            state_q <= S_XFER;
            owner_q <= w_pick;
            grant_q <= c_onehot0 << w_pick;
            busy_q  <= 1'b1;
          end
        end
        S_XFER: begin
          if (w_done || w_abort) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= w_next_ptr;
            grant_q  <= '0;
            busy_q   <= 1'b0;
            if (w_abort) begin
              timeout_q     <= 1'b1;
              timeout_req_q <= owner_q;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.writereq_o  = w_accept;
  assign bus.data_o      = w_accept ? w_own_data : '0;
  assign bus.req_ready_o = (w_xfer && !bus.full_i) ? grant_q : '0;

  assign grant_o       = grant_q;
  assign busy_o        = busy_q;
  assign timeout_o     = timeout_q;
  assign timeout_req_o = timeout_req_q;

`ifdef HOST_TX_ARB_STATS_EN
  logic [15:0] pkt_count_q;
  logic [15:0] pkt_count_d;
  logic [15:0] stall_count_q;
  logic [15:0] stall_count_d;

  // Packet count wraps; stall count saturates.
  always_comb begin
    pkt_count_d   = pkt_count_q + {15'd0, w_done};
    stall_count_d = stall_count_q;
    if (w_xfer && w_own_valid && bus.full_i && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_count_q   <= '0;
      stall_count_q <= '0;
    end else begin
      pkt_count_q   <= pkt_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign pkt_count_o   = pkt_count_q;
  assign stall_count_o = stall_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_host_tx_arbiter.sv
`default_nettype none
// ============================================================================
// tb_host_tx_arbiter : directed self-checking bench for host_tx_arbiter.
// Revision: 1.0
// ============================================================================
module tb_host_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DW      = 8;
  localparam int IW      = 2;
  localparam int TO      = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  host_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW)) bus ();

  logic [NUM_REQ-1:0] grant;
  logic               busy;
  logic               tmo;
  logic [IW-1:0]      tmo_req;
`ifdef HOST_TX_ARB_STATS_EN
  logic [15:0]        pkt_count;
  logic [15:0]        stall_count;
`endif

  host_tx_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .DATA_WIDTH (DW),
    .IDX_WIDTH  (IW),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .grant_o      (grant),
    .busy_o       (busy),
    .timeout_o    (tmo),
    .timeout_req_o(tmo_req)
`ifdef HOST_TX_ARB_STATS_EN
    ,
    .pkt_count_o  (pkt_count),
    .stall_count_o(stall_count)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_req(input int k, input logic v, input logic [7:0] d, input logic l);
    bus.req_valid_i[k]       = v;
    bus.req_data_i[k*DW +: DW] = d;
    bus.req_last_i[k]        = l;
  endtask

  task automatic clear_all();
    bus.req_valid_i = '0;
    bus.req_data_i  = '0;
    bus.req_last_i  = '0;
    bus.full_i      = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_all();
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    bus.full_i = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) set_req(k, 1'b1, 8'h5A, 1'b1);
    #1 rst = 1'b0;
    #2;
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_grant_busy: grant=%b busy=%b required 0000/0", grant, busy);
    end
    checks++;
    if (bus.writereq_o !== 1'b0 || bus.data_o !== 8'h00 || bus.req_ready_o !== 4'b0000) begin
      errors++;
      $display("FAIL reset_fifo_port: wr=%b data=%h ready=%b required 0/00/0000",
               bus.writereq_o, bus.data_o, bus.req_ready_o);
    end
    checks++;
    if (tmo !== 1'b0 || tmo_req !== 2'd0) begin
      errors++;
      $display("FAIL reset_timeout: tmo=%b tmo_req=%0d required 0/0", tmo, tmo_req);
    end
    step();
    settle();
    checks++;
    if (grant !== 4'b0000 || bus.writereq_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_held: grant=%b wr=%b required 0000/0", grant, bus.writereq_o);
    end
`ifdef HOST_TX_ARB_STATS_EN
    checks++;
    if (pkt_count !== 16'd0 || stall_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_stats: pkt=%0d stall=%0d required 0/0", pkt_count, stall_count);
    end
`endif
    clear_all();
    step();
    rst = 1'b1;
  endtask

  task automatic test_single_packet();
    set_req(0, 1'b1, 8'h10, 1'b0);
    settle();
    checks++;
    if (bus.writereq_o !== 1'b0 || grant !== 4'b0000) begin
      errors++;
      $display("FAIL single_idle_gap: wr=%b grant=%b required 0/0000", bus.writereq_o, grant);
    end
    step();
    settle();
    checks++;
    if (grant !== 4'b0001 || busy !== 1'b1 || bus.req_ready_o !== 4'b0001) begin
      errors++;
      $display("FAIL single_grant: grant=%b busy=%b ready=%b required 0001/1/0001",
               grant, busy, bus.req_ready_o);
    end
    checks++;
    if (bus.writereq_o !== 1'b1 || bus.data_o !== 8'h10) begin
      errors++;
      $display("FAIL single_byte0: wr=%b data=%h required 1/10", bus.writereq_o, bus.data_o);
    end
    step();
    set_req(0, 1'b1, 8'h15, 1'b0);
    settle();
    checks++;
    if (bus.writereq_o !== 1'b1 || bus.data_o !== 8'h15) begin
      errors++;
      $display("FAIL single_byte1: wr=%b data=%h required 1/15", bus.writereq_o, bus.data_o);
    end
    step();
    set_req(0, 1'b1, 8'h2A, 1'b1);
    settle();
    checks++;
    if (bus.writereq_o !== 1'b1 || bus.data_o !== 8'h2A) begin
      errors++;
      $display("FAIL single_byte2: wr=%b data=%h required 1/2a", bus.writereq_o, bus.data_o);
    end
    step();
    set_req(0, 1'b0, 8'h00, 1'b0);
    settle();
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b0 || bus.writereq_o !== 1'b0) begin
      errors++;
      $display("FAIL single_release: grant=%b busy=%b wr=%b required 0000/0/0",
               grant, busy, bus.writereq_o);
    end
    // rr_ptr should now be 1: req 1 beats req 0.
    set_req(0, 1'b1, 8'hA0, 1'b1);
    set_req(1, 1'b1, 8'hA1, 1'b1);
    step();
    settle();
    checks++;
    if (grant !== 4'b0010 || bus.data_o !== 8'hA1 || bus.writereq_o !== 1'b1) begin
      errors++;
      $display("FAIL rr_after_packet: grant=%b data=%h wr=%b required 0010/a1/1",
               grant, bus.data_o, bus.writereq_o);
    end
    step();
    set_req(1, 1'b0, 8'h00, 1'b0);
    step();
    settle();
    checks++;
    if (grant !== 4'b0001 || bus.data_o !== 8'hA0) begin
      errors++;
      $display("FAIL rr_then_req0: grant=%b data=%h required 0001/a0", grant, bus.data_o);
    end
    step();
    clear_all();
  endtask

  task automatic test_all_four();
    logic [3:0] exp_g;
    bit         bad;
    do_reset();
    for (int k = 0; k < NUM_REQ; k++) set_req(k, 1'b1, 8'hB0 + 8'(k), 1'b0);
    for (int p = 0; p < NUM_REQ; p++) begin
      exp_g = 4'b0001 << p;
      settle();
      checks++;
      if (grant !== 4'b0000 || bus.writereq_o !== 1'b0) begin
        errors++;
        $display("FAIL all4_idle[%0d]: grant=%b wr=%b required 0000/0", p, grant, bus.writereq_o);
      end
      step();
      settle();
      bad = (grant !== exp_g) || (bus.writereq_o !== 1'b1) || (bus.data_o !== 8'hB0 + 8'(p));
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL all4_first[%0d]: grant=%b wr=%b data=%h required %b/1/%h",
                 p, grant, bus.writereq_o, bus.data_o, exp_g, 8'hB0 + 8'(p));
      end
      step();
      set_req(p, 1'b1, 8'hC0 + 8'(p), 1'b1);
      settle();
      checks++;
      if (grant !== exp_g || bus.writereq_o !== 1'b1 || bus.data_o !== 8'hC0 + 8'(p)) begin
        errors++;
        $display("FAIL all4_last[%0d]: grant=%b wr=%b data=%h required %b/1/%h",
                 p, grant, bus.writereq_o, bus.data_o, exp_g, 8'hC0 + 8'(p));
      end
      step();
      set_req(p, 1'b0, 8'h00, 1'b0);
    end
`ifdef HOST_TX_ARB_STATS_EN
    settle();
    checks++;
    if (pkt_count !== 16'd4) begin
      errors++;
      $display("FAIL all4_pkt_count: got %0d required 4", pkt_count);
    end
`endif
    clear_all();
  endtask

  task automatic test_backpressure();
    bit         bad;
    int         bad_i;
    logic       bad_wr;
    logic [3:0] bad_rdy;
    bad = 1'b0;
    bad_i = 0;
    bad_wr = 1'b0;
    bad_rdy = '0;
    set_req(2, 1'b1, 8'h21, 1'b0);
    step();
    settle();
    checks++;
    if (grant !== 4'b0100 || bus.writereq_o !== 1'b1 || bus.data_o !== 8'h21) begin
      errors++;
      $display("FAIL bp_first: grant=%b wr=%b data=%h required 0100/1/21",
               grant, bus.writereq_o, bus.data_o);
    end
    step();
    set_req(2, 1'b1, 8'h22, 1'b1);
    bus.full_i = 1'b1;
    for (int i = 0; i < 100; i++) begin
      settle();
      if (!bad && (bus.writereq_o !== 1'b0 || bus.req_ready_o !== 4'b0000 ||
                   tmo !== 1'b0 || grant !== 4'b0100)) begin
        bad = 1'b1; bad_i = i; bad_wr = bus.writereq_o; bad_rdy = bus.req_ready_o;
      end
      step();
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL bp_hold: cycle %0d wr=%b ready=%b required 0/0000 with grant held, no timeout",
               bad_i, bad_wr, bad_rdy);
    end
    bus.full_i = 1'b0;
    settle();
    checks++;
    if (bus.writereq_o !== 1'b1 || bus.data_o !== 8'h22 || bus.req_ready_o !== 4'b0100) begin
      errors++;
      $display("FAIL bp_resume: wr=%b data=%h ready=%b required 1/22/0100",
               bus.writereq_o, bus.data_o, bus.req_ready_o);
    end
`ifdef HOST_TX_ARB_STATS_EN
    checks++;
    if (stall_count !== 16'd100) begin
      errors++;
      $display("FAIL bp_stall_count: got %0d required 100", stall_count);
    end
`endif
    step();
    clear_all();
  endtask

  task automatic test_watchdog();
    bit         bad;
    int         bad_i;
    logic [3:0] bad_g;
    bad = 1'b0;
    bad_i = 0;
    bad_g = '0;
    set_req(1, 1'b1, 8'h31, 1'b0);
    set_req(2, 1'b1, 8'hEE, 1'b1);
    step();
    settle();
    checks++;
    if (grant !== 4'b0010 || bus.writereq_o !== 1'b1 || bus.data_o !== 8'h31) begin
      errors++;
      $display("FAIL wd_first: grant=%b wr=%b data=%h required 0010/1/31",
               grant, bus.writereq_o, bus.data_o);
    end
    step();
    set_req(1, 1'b0, 8'h00, 1'b0);
    for (int i = 1; i <= TO; i++) begin
      settle();
      if (!bad && (grant !== 4'b0010 || bus.writereq_o !== 1'b0 || tmo !== 1'b0)) begin
        bad = 1'b1; bad_i = i; bad_g = grant;
      end
      step();
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL wd_idle_window: idle cycle %0d grant=%b required 0010, no write, no timeout",
               bad_i, bad_g);
    end
    settle();
    checks++;
    if (tmo !== 1'b1 || tmo_req !== 2'd1 || grant !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL wd_abort: tmo=%b tmo_req=%0d grant=%b busy=%b required 1/1/0000/0",
               tmo, tmo_req, grant, busy);
    end
    step();
    settle();
    checks++;
    if (tmo !== 1'b0 || tmo_req !== 2'd1) begin
      errors++;
      $display("FAIL wd_pulse: tmo=%b tmo_req=%0d required 0/1", tmo, tmo_req);
    end
    checks++;
    if (grant !== 4'b0100 || bus.writereq_o !== 1'b1 || bus.data_o !== 8'hEE) begin
      errors++;
      $display("FAIL wd_next_grant: grant=%b wr=%b data=%h required 0100/1/ee",
               grant, bus.writereq_o, bus.data_o);
    end
    step();
    clear_all();
  endtask

  task automatic test_rr_wrap();
    set_req(0, 1'b1, 8'h50, 1'b1);
    set_req(3, 1'b1, 8'h53, 1'b1);
    step();
    settle();
    checks++;
    if (grant !== 4'b1000 || bus.data_o !== 8'h53 || bus.writereq_o !== 1'b1) begin
      errors++;
      $display("FAIL wrap_req3: grant=%b data=%h wr=%b required 1000/53/1",
               grant, bus.data_o, bus.writereq_o);
    end
    step();
    set_req(3, 1'b0, 8'h00, 1'b0);
    settle();
    checks++;
    if (grant !== 4'b0000 || bus.writereq_o !== 1'b0) begin
      errors++;
      $display("FAIL wrap_gap: grant=%b wr=%b required 0000/0", grant, bus.writereq_o);
    end
    step();
    settle();
    checks++;
    if (grant !== 4'b0001 || bus.data_o !== 8'h50 || bus.writereq_o !== 1'b1) begin
      errors++;
      $display("FAIL wrap_req0: grant=%b data=%h wr=%b required 0001/50/1",
               grant, bus.data_o, bus.writereq_o);
    end
    step();
    clear_all();
  endtask

  task automatic test_async_reset();
    set_req(3, 1'b1, 8'h61, 1'b0);
    step();
    settle();
    checks++;
    if (grant !== 4'b1000 || bus.writereq_o !== 1'b1 || bus.data_o !== 8'h61) begin
      errors++;
      $display("FAIL areset_pre: grant=%b wr=%b data=%h required 1000/1/61",
               grant, bus.writereq_o, bus.data_o);
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if (grant !== 4'b0000 || bus.writereq_o !== 1'b0 || busy !== 1'b0 ||
        bus.req_ready_o !== 4'b0000) begin
      errors++;
      $display("FAIL areset_immediate: grant=%b wr=%b busy=%b ready=%b required 0000/0/0/0000",
               grant, bus.writereq_o, busy, bus.req_ready_o);
    end
    set_req(0, 1'b1, 8'h70, 1'b1);
    step();
    rst = 1'b1;
    settle();
    checks++;
    if (grant !== 4'b0000 || bus.writereq_o !== 1'b0) begin
      errors++;
      $display("FAIL areset_idle: grant=%b wr=%b required 0000/0", grant, bus.writereq_o);
    end
    step();
    settle();
    checks++;
    if (grant !== 4'b0001 || bus.data_o !== 8'h70) begin
      errors++;
      $display("FAIL areset_restart: grant=%b data=%h required 0001/70", grant, bus.data_o);
    end
    step();
    clear_all();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1);
  end

  initial begin
    clear_all();
    test_reset();
    test_single_packet();
    test_all_four();
    test_backpressure();
    test_watchdog();
    test_rr_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/host_tx_arbiter.md
Name: host_tx_arbiter

Overview:
- Shares the single byte-wide write port of the outbound message FIFO between NUM_REQ host interface controllers.
- Each requester streams a packet: connect, disconnect, or a send_data header/length/payload sequence.
- The arbiter grants the FIFO to one requester per packet, round-robin. Bytes from different requesters are never interleaved.
- A watchdog aborts a granted requester that stalls mid-packet.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 8, byte width of each requester's data lane.
- IDX_WIDTH, 2, width of requester index (must be ≥ clog2(NUM_REQ)).
- TIMEOUT_CYC, 64, idle cycles tolerated mid-packet before abort; 0 disables the watchdog.

Ports:
- clk, input, 1, system clock, rising edge.
- rst, input, 1, asynchronous active-low reset.
- req_valid_i, input, NUM_REQ, per-requester byte valid.
- req_data_i, input, NUM_REQ*DATA_WIDTH, flattened data; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- req_last_i, input, NUM_REQ, marks the final byte of the packet; qualified by valid.
- req_ready_o, output, NUM_REQ, byte accepted this cycle when valid&ready.
- full_i, input, 1, FIFO full.
- writereq_o, output, 1, FIFO write strobe.
- data_o, output, DATA_WIDTH, FIFO write data.
- grant_o, output, NUM_REQ, one-hot current owner; 0 when idle.
- busy_o, output, 1, high while in XFER.
- timeout_o, output, 1, one-cycle pulse on abort.
- timeout_req_o, output, IDX_WIDTH, index of the aborted requester; held until the next abort.

Behaviour:
- Reset (rst low, async):
  - state=IDLE; rr_ptr=0; grant_o=0; busy_o=0; timeout_o=0; timeout_req_o=0; watchdog count=0.
  - writereq_o=0, data_o=0, req_ready_o=0 (combinational, forced by state).
- State IDLE:
  - Scan req_valid_i starting at rr_ptr, wrapping modulo NUM_REQ.
  - First set bit k registers grant=k and moves to XFER next cycle.
  - No bytes are accepted in IDLE.
  - No valid requesters: stay in IDLE.
- State XFER (owner g):
  - req_ready_o[g] = ~full_i; all other ready bits are 0.
  - writereq_o = req_valid_i[g] & ~full_i; data_o = req_data_i[g] (combinational, zero latency); data_o=0 when writereq_o=0.
  - Accepted byte with req_last_i[g]=1: state goes to IDLE, rr_ptr = (g+1) mod NUM_REQ, grant cleared next cycle.
  - Minimum one IDLE cycle between packets.
- Watchdog:
  - In XFER, the count increments on cycles where req_valid_i[g]=0.
  - Cycles where full_i=1 do not count (backpressure is not a fault).
  - Count clears on any accepted byte and on entry to XFER.
  - When count reaches TIMEOUT_CYC (nonzero): no write that cycle; pulse timeout_o; timeout_req_o=g; state to IDLE; rr_ptr=(g+1) mod NUM_REQ.
- Boundary conditions:
  - Single-byte packet (valid&last on first XFER cycle) is legal: one write, back to IDLE.
  - full_i asserted on the last byte: hold in XFER, last byte written once full_i drops.
  - Simultaneous requests: the requester at or after rr_ptr wins; rr_ptr wrap from NUM_REQ-1 to 0.
  - Requester deasserting valid mid-packet: grant held, no writes until valid returns or watchdog fires.
  - Non-owner valid bits are ignored during XFER; their data is never written.
  - Reset asserted mid-packet: immediate return to IDLE, partial packet abandoned (FIFO contents not touched).
  - Counter widths are sized to hold TIMEOUT_CYC; no overflow wrap.

Optional Feature:
- Macro: HOST_TX_ARB_STATS_EN.
- When defined, adds two outputs:
  - pkt_count_o [15:0]: increments on each completed packet (last byte accepted); wraps at 65535→0; timeouts excluded.
  - stall_count_o [15:0]: increments each XFER cycle with req_valid_i[g]=1 and full_i=1; saturates at 65535.
  - Both reset to 0.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Req 0 alone sends a 3-byte packet 0x10,0x15,0x2A (last on 0x2A), full_i=0 → IDLE 1 cycle, then writereq_o high 3 consecutive cycles with those bytes; grant_o=0001 during XFER; rr_ptr=1 afterwards.
- Reqs 0..3 all valid with 2-byte packets → grants in order 0,1,2,3; no interleaving on data_o; pkt_count_o=4 with STATS_EN.
- Req 2 mid-packet, full_i held high 100 cycles → no writes, no timeout, stall_count_o=100; bytes resume when full_i drops.
- Req 1 sends 1 byte, then drops valid with TIMEOUT_CYC=64 → timeout_o pulses after exactly 64 idle cycles, timeout_req_o=1, next grant goes to req 2 if it is valid.
- rr_ptr=3 with reqs 0 and 3 valid → req 3 granted first, then req 0 (wrap).
- rst driven low mid-packet asynchronously → grant_o, writereq_o, busy_o go to 0 without a clock edge; after release, arbitration restarts from req 0.
